// File: rtl/sync_seq_pkg.sv
// Shared widths and state encoding for the sync-driven frame/line sequencer.
package sync_seq_pkg;

  localparam int LINE_IDX_W  = 12;
  localparam int FRAME_CNT_W = 16;
  localparam int PIX_CNT_W   = 16;
  localparam int WDOG_W      = 24;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_DELAY     = 2'd2,
    ST_ACTIVE    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sync_frame_seq_if.sv
// Control and timing-output bundle between the sequencer and its client.
interface sync_frame_seq_if;
  import sync_seq_pkg::*;

  logic                   i_en;
  logic                   i_sync_pulse;
  logic                   o_frame_start;
  logic                   o_line_start;
  logic                   o_line_valid;
  logic [LINE_IDX_W-1:0]  o_line_idx;
  logic [FRAME_CNT_W-1:0] o_frame_cnt;
  logic                   o_busy;
  logic                   o_sync_lost;
  logic                   o_overrun;

  modport master (
    output i_en, i_sync_pulse,
    input  o_frame_start, o_line_start, o_line_valid, o_line_idx,
           o_frame_cnt, o_busy, o_sync_lost, o_overrun
  );

  modport slave (
    input  i_en, i_sync_pulse,
    output o_frame_start, o_line_start, o_line_valid, o_line_idx,
           o_frame_cnt, o_busy, o_sync_lost, o_overrun
  );

endinterface

// File: rtl/sync_watchdog.sv
// Sync-loss watchdog: counts enabled clocks and pulses once every TIMEOUT_CYC of them.
module sync_watchdog
  import sync_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic timeout
);

  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] cnt_q;

  // The pulse is valid in the cycle whose closing edge restarts the count.
  assign timeout = cnt_en && (cnt_q == WD_LAST);

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= timeout ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sync_frame_seq.sv
// Frame/line sequencer: sync -> programmable delay -> LINES line periods with line-valid windows.
module sync_frame_seq
  import sync_seq_pkg::*;
#(
  parameter int DELAY_CYC   = 16,
  parameter int LINE_PERIOD = 1000,
  parameter int LINE_ACTIVE = 800,
  parameter int LINES       = 480,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic            clk_100,
  input logic            rst_n,
  sync_frame_seq_if.slave bus
);

  localparam logic [PIX_CNT_W-1:0]  DLY_LAST = PIX_CNT_W'(DELAY_CYC - 1);
  localparam logic [PIX_CNT_W-1:0]  PIX_LAST = PIX_CNT_W'(LINE_PERIOD - 1);
  localparam logic [PIX_CNT_W-1:0]  ACT_LIM  = PIX_CNT_W'(LINE_ACTIVE);
  localparam logic [LINE_IDX_W-1:0] LINE_LAST = LINE_IDX_W'(LINES - 1);

  seq_state_e             state_q, state_d;
  logic [PIX_CNT_W-1:0]   dly_q, dly_d;
  logic [PIX_CNT_W-1:0]   pix_q, pix_d;
  logic [LINE_IDX_W-1:0]  line_q, line_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   sync_lost_q, sync_lost_d;
  logic                   frame_start_q, frame_start_d;
  logic                   line_start_q, line_start_d;
  logic                   line_valid_q, line_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic last_clk, sync_accept, wd_clr, wd_en, wd_timeout;

  // A sync on the final ACTIVE clock chains straight into the next frame.
  assign last_clk    = (state_q == ST_ACTIVE) && (pix_q == PIX_LAST) && (line_q == LINE_LAST);
  assign sync_accept = bus.i_en && bus.i_sync_pulse && ((state_q == ST_WAIT_SYNC) || last_clk);
  assign wd_clr      = !bus.i_en || (state_q == ST_IDLE) || sync_accept;
  assign wd_en       = bus.i_en && (state_q == ST_WAIT_SYNC) && !bus.i_sync_pulse;

  sync_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .cnt_en  (wd_en),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    pix_d       = pix_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    sync_lost_d = sync_lost_q;
    overrun_d   = 1'b0;

    if (!bus.i_en) begin
      state_d     = ST_IDLE;
      sync_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_WAIT_SYNC;
        ST_WAIT_SYNC: begin
          if (bus.i_sync_pulse) begin
            state_d     = ST_DELAY;
            dly_d       = '0;
            sync_lost_d = 1'b0;
          end else if (wd_timeout) begin
            sync_lost_d = 1'b1;
          end
        end
        ST_DELAY: begin
          overrun_d = bus.i_sync_pulse;
          if (dly_q == DLY_LAST) begin
            state_d = ST_ACTIVE;
            pix_d   = '0;
            line_d  = '0;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (last_clk) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (bus.i_sync_pulse) begin
              state_d     = ST_DELAY;
              dly_d       = '0;
              sync_lost_d = 1'b0;
            end else begin
              state_d = ST_WAIT_SYNC;
            end
          end else begin
            overrun_d = bus.i_sync_pulse;
            if (pix_q == PIX_LAST) begin
              pix_d  = '0;
              line_d = line_q + 1'b1;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    if (state_d != ST_ACTIVE) begin
      line_d = '0;
    end
    frame_start_d = (state_q == ST_DELAY) && (state_d == ST_ACTIVE);
    line_start_d  = (state_d == ST_ACTIVE) && (pix_d == '0);
    line_valid_d  = (state_d == ST_ACTIVE) && (pix_d < ACT_LIM);
    busy_d        = (state_d == ST_DELAY) || (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dly_q         <= '0;
      pix_q         <= '0;
      line_q        <= '0;
      frame_cnt_q   <= '0;
      sync_lost_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      line_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      pix_q         <= pix_d;
      line_q        <= line_d;
      frame_cnt_q   <= frame_cnt_d;
      sync_lost_q   <= sync_lost_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      line_valid_q  <= line_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.o_frame_start = frame_start_q;
  assign bus.o_line_start  = line_start_q;
  assign bus.o_line_valid  = line_valid_q;
  assign bus.o_line_idx    = line_q;
  assign bus.o_frame_cnt   = frame_cnt_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_sync_lost   = sync_lost_q;
  assign bus.o_overrun     = overrun_q;

endmodule
